uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter: DEPTH, 16, number of stored entries; power of two, 2..256.
REQ-002 clk  input  1  single system clock; all registers update on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 data  input  8  received byte from the UART receiver.
REQ-005 error_parity  input  1  parity error flag accompanying data.
REQ-006 error_frame  input  1  frame error flag accompanying data.
REQ-007 newData  input  1  one-cycle pulse; data and both error flags are valid in this cycle.
REQ-008 flush  input  1  discard all stored entries.
REQ-009 rd_en  input  1  consumer pops the head entry.
REQ-010 ov_clear  input  1  clears the sticky overflow flag.
REQ-011 data_out  output  8  head entry byte.
REQ-012 err_parity_out  output  1  head entry parity error.
REQ-013 err_frame_out  output  1  head entry frame error.
REQ-014 valid  output  1  FIFO non-empty; head outputs meaningful.
REQ-015 full  output  1  count == DEPTH.
REQ-016 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-017 overflow  output  1  sticky flag; a push was dropped.

Function
REQ-018 Entry SHALL be 10 bits: {error_frame, error_parity, data[7:0]}; storage is write-pointer/read-pointer circular buffer, pointers $clog2(DEPTH) bits, wrap modulo DEPTH.
REQ-019 Push SHALL occur on cycle N when newData=1 and (full=0 or a pop occurs in the same cycle); entry visible, valid=1, count updated at cycle N+1.
REQ-020 Pop SHALL occur when rd_en=1 and valid=1; the next entry (or valid=0) appears at cycle N+1; rd_en with valid=0 is ignored, with no state change.
REQ-021 Head outputs SHALL reflect the oldest entry combinationally from the read pointer (first-word-fall-through); values SHALL be 0 when valid=0.
REQ-022 Simultaneous push and pop SHALL keep count unchanged, including when full (the pop frees the slot, so no overflow) and when count==1.
REQ-023 Push while full without a pop SHALL drop the entry, leave contents and pointers unchanged, and set overflow=1 at N+1.
REQ-024 overflow SHALL stay 1 until ov_clear=1 or rst; if ov_clear and a new overflow coincide, overflow SHALL remain 1.
REQ-025 flush SHALL zero both pointers and count at N+1; flush has priority over a same-cycle push and pop (both discarded); overflow SHALL be unaffected.
REQ-026 count SHALL saturate logically at DEPTH and never underflow; full = (count==DEPTH); valid = (count!=0).
REQ-027 Error flags SHALL be stored per entry exactly as sampled with newData, with no filtering; erroneous bytes are still queued.

Reset
REQ-028 On rst=1 at a posedge SHALL force pointers=0, count=0, overflow=0 at the next cycle; rst overrides flush, newData, rd_en and ov_clear.
REQ-029 After reset: valid=0, full=0, data_out=0, err_parity_out=0, err_frame_out=0.
REQ-030 Storage array SHALL need no reset; reset mid-stream discards all contents.

Structure
REQ-031 Entry width (10), bit positions of the two error flags, and default DEPTH SHALL be defined as constants in the shared UART header included by all UART blocks.
REQ-032 Storage SHALL be a sub-module uart_fifo_mem (DEPTH x 10, one synchronous write port, one asynchronous read port); pointer/count/flag control stays in uart_rx_fifo.

Verification
REQ-033 Reset, then one newData with data=8'hA5, parity err=1, frame err=0 -> next cycle valid=1, count=1, data_out=8'hA5, err_parity_out=1; rd_en -> valid=0, count=0.
REQ-034 Push 16 bytes 8'h00..8'h0F (DEPTH=16) -> full=1; 17th push 8'hFF -> overflow=1, count=16; popping yields 00..0F in order with no FF; ov_clear -> overflow=0.
REQ-035 Full FIFO, newData=8'h55 and rd_en in the same cycle -> count stays 16, overflow stays 0, 8'h55 is read last.
REQ-036 Run 40 push/pop pairs with count oscillating 0..3 -> pointers wrap; byte order preserved; rd_en while empty causes no count change.
REQ-037 count=5, then flush with newData and rd_en in the same cycle -> next cycle count=0, valid=0, overflow unchanged.
REQ-038 count=7 with overflow=1, assert rst -> next cycle count=0, valid=0, overflow=0, data_out=0.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: receive-entry layout and default FIFO depth.
// Every UART block imports this package so the entry format is defined in one place.
package uart_rx_fifo_pkg;

    localparam int unsigned ENTRY_W       = 10;
    localparam int unsigned DATA_W        = 8;
    localparam int unsigned PARITY_BIT    = 8;
    localparam int unsigned FRAME_BIT     = 9;
    localparam int unsigned DEFAULT_DEPTH = 16;

    typedef logic [ENTRY_W-1:0] entry_t;

    function automatic entry_t pack_entry(input logic [DATA_W-1:0] data,
                                          input logic parity, input logic frame);
        return {frame, parity, data};
    endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Entry storage for the UART receive FIFO: synchronous write, asynchronous read.
// Holds no reset; the control logic decides which slots are meaningful.
module uart_fifo_mem
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: queues each received byte with its parity/frame error flags,
// presenting the oldest entry first-word-fall-through, with a sticky overflow flag.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               data,
    input  logic                     error_parity,
    input  logic                     error_frame,
    input  logic                     newData,
    input  logic                     flush,
    input  logic                     rd_en,
    input  logic                     ov_clear,
    output logic [7:0]               data_out,
    output logic                     err_parity_out,
    output logic                     err_frame_out,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;
    logic          push;
    logic          ov_set;
    logic          mem_we;
    entry_t        head;

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = rd_en && valid;
    // A same-cycle pop frees the slot, so a push into a full FIFO is still accepted.
    assign push  = newData && (!full || pop);
    assign ov_set = newData && full && !pop && !flush;
    assign mem_we = push && !flush && !rst;

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (pack_entry(data, error_parity, error_frame)),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)      count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
            // A fresh overflow wins over a coincident clear.
            if (ov_set)        overflow <= 1'b1;
            else if (ov_clear) overflow <= 1'b0;
        end
    end

    always_comb begin
        data_out       = '0;
        err_parity_out = 1'b0;
        err_frame_out  = 1'b0;
        if (valid) begin
            data_out       = head[DATA_W-1:0];
            err_parity_out = head[PARITY_BIT];
            err_frame_out  = head[FRAME_BIT];
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (DEPTH=16): a directed vector table plus
// hand-written sequences for full/overflow, wrap, flush and mid-stream reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = '0;
    logic       error_parity = 1'b0;
    logic       error_frame = 1'b0;
    logic       newData = 1'b0;
    logic       flush = 1'b0;
    logic       rd_en = 1'b0;
    logic       ov_clear = 1'b0;
    logic [7:0] data_out;
    logic       err_parity_out;
    logic       err_frame_out;
    logic       valid;
    logic       full;
    logic [4:0] count;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .data           (data),
        .error_parity   (error_parity),
        .error_frame    (error_frame),
        .newData        (newData),
        .flush          (flush),
        .rd_en          (rd_en),
        .ov_clear       (ov_clear),
        .data_out       (data_out),
        .err_parity_out (err_parity_out),
        .err_frame_out  (err_frame_out),
        .valid          (valid),
        .full           (full),
        .count          (count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       nd;
        logic [7:0] d;
        logic       pe, fe, rd, fl, oc, r;
        logic       ev;
        int         ec;
        logic [7:0] ed;
        logic       ep, ef, efull, eov;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic nd, input logic [7:0] d, input logic pe, input logic fe,
                        input logic rd, input logic fl, input logic oc, input logic r);
        @(negedge clk);
        newData = nd; data = d; error_parity = pe; error_frame = fe;
        rd_en = rd; flush = fl; ov_clear = oc; rst = r;
        @(posedge clk);
        #1;
        newData = 1'b0; rd_en = 1'b0; flush = 1'b0; ov_clear = 1'b0; rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // nd  d     pe    fe    rd    fl    oc    r   | v     cnt d      p     f     full  ov
        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].nd, vecs[i].d, vecs[i].pe, vecs[i].fe,
                 vecs[i].rd, vecs[i].fl, vecs[i].oc, vecs[i].r);
            chk($sformatf("vec%0d valid", i), valid, vecs[i].ev);
            chk($sformatf("vec%0d count", i), count, vecs[i].ec);
            chk($sformatf("vec%0d data_out", i), data_out, vecs[i].ed);
            chk($sformatf("vec%0d err_parity", i), err_parity_out, vecs[i].ep);
            chk($sformatf("vec%0d err_frame", i), err_frame_out, vecs[i].ef);
            chk($sformatf("vec%0d full", i), full, vecs[i].efull);
            chk($sformatf("vec%0d overflow", i), overflow, vecs[i].eov);
        end

        // Fill to 16, then overflow, sticky against coincident clear, in-order drain.
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("fill full", full, 1);
        chk("fill count", count, 16);
        chk("fill ovf", overflow, 0);
        push(8'hFF);
        chk("ovf set", overflow, 1);
        chk("ovf count", count, 16);
        chk("ovf head", data_out, 8'h00);
        step(1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf vs clear", overflow, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain head %0d", i), data_out, i);
            pop();
        end
        chk("drain empty", valid, 0);
        chk("drain count", count, 0);
        chk("ovf sticky", overflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("ovf clear", overflow, 0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pp full count", count, 16);
        chk("pp full ovf", overflow, 0);
        chk("pp full head", data_out, 8'h31);
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("pp drain %0d", i), data_out, 8'h30 + i);
            pop();
        end
        chk("pp last", data_out, 8'h55);
        pop();
        chk("pp empty", valid, 0);

        // Wrap test: groups of three pushes then three pops, empty pop in between.
        begin
            int next_in;
            int next_out;
            next_in = 0;
            next_out = 0;
            for (int g = 0; g < 14; g++) begin
                for (int k = 0; k < 3; k++) begin
                    push(8'(next_in * 7 + 1));
                    next_in++;
                    chk("wrap push count", count, k + 1);
                end
                for (int k = 0; k < 3; k++) begin
                    chk("wrap order", data_out, (next_out * 7 + 1) & 8'hFF);
                    next_out++;
                    pop();
                    chk("wrap pop count", count, 2 - k);
                end
                pop();
                chk("empty pop count", count, 0);
            end
        end

        // Flush with overflow set, count 5, and same-cycle push/pop.
        for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
        push(8'hEE);
        for (int i = 0; i < 11; i++) pop();
        chk("pre-flush count", count, 5);
        chk("pre-flush ovf", overflow, 1);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("flush count", count, 0);
        chk("flush valid", valid, 0);
        chk("flush ovf", overflow, 1);
        push(8'h77);
        chk("post-flush head", data_out, 8'h77);
        chk("post-flush count", count, 1);

        // Mid-stream reset overriding every other control input.
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        chk("pre-rst count", count, 7);
        step(1'b1, 8'h12, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("rst count", count, 0);
        chk("rst valid", valid, 0);
        chk("rst ovf", overflow, 0);
        chk("rst data_out", data_out, 0);
        chk("rst full", full, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
